// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
package mc_pkg;

  // FSM states; the numeric values are visible on the state debug port.
  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    ClsR,
    ClsIArith,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsBne,
    ClsJ,
    ClsIllegal
  } inst_cls_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101011;
  localparam logic [5:0] FnSll = 6'b000100;

  // ALU operation encodings
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluXor = 3'b010;
  localparam logic [2:0] AluNor = 3'b011;
  localparam logic [2:0] AluAdd = 3'b100;
  localparam logic [2:0] AluSub = 3'b101;
  localparam logic [2:0] AluSlt = 3'b110;
  localparam logic [2:0] AluSll = 3'b111;

  // PC source select
  localparam logic [1:0] PcSelSeq    = 2'b00;
  localparam logic [1:0] PcSelBranch = 2'b01;
  localparam logic [1:0] PcSelJump   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] AluBRt     = 2'b00;
  localparam logic [1:0] AluBFour   = 2'b01;
  localparam logic [1:0] AluBImm    = 2'b10;
  localparam logic [1:0] AluBImmSh2 = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/func -> class, EX-stage ALU op, immediate extension.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_code_i,
  input  logic [5:0] func_i,
  output inst_cls_e  cls_o,
  output logic [2:0] alu_op_o,
  output logic       imm_s_o
);

  // Classify the instruction; anything not recognised falls out as ClsIllegal.
  always_comb begin
    cls_o    = ClsIllegal;
    alu_op_o = AluAdd;
    imm_s_o  = 1'b0;
    case (op_code_i)
      OpRType: begin
        cls_o = ClsR;
        case (func_i)
          FnAdd:   alu_op_o = AluAdd;
          FnSub:   alu_op_o = AluSub;
          FnAnd:   alu_op_o = AluAnd;
          FnOr:    alu_op_o = AluOr;
          FnXor:   alu_op_o = AluXor;
          FnNor:   alu_op_o = AluNor;
          FnSlt:   alu_op_o = AluSlt;
          FnSll:   alu_op_o = AluSll;
          default: cls_o    = ClsIllegal;
        endcase
      end
      OpAddi: begin
        cls_o   = ClsIArith;
        imm_s_o = 1'b1;
      end
      OpAndi: begin
        cls_o    = ClsIArith;
        alu_op_o = AluAnd;
      end
      OpXori: begin
        cls_o    = ClsIArith;
        alu_op_o = AluXor;
      end
      OpSltiu: begin
        cls_o    = ClsIArith;
        alu_op_o = AluSlt;
      end
      OpLw: begin
        cls_o   = ClsLw;
        imm_s_o = 1'b1;
      end
      OpSw: begin
        cls_o   = ClsSw;
        imm_s_o = 1'b1;
      end
      OpBeq: begin
        cls_o    = ClsBeq;
        alu_op_o = AluSub;
      end
      OpBne: begin
        cls_o    = ClsBne;
        alu_op_o = AluSub;
      end
      OpJ:     cls_o = ClsJ;
      default: cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: IF/ID/EX/MEM/WB sequencer, datapath strobes/selects and
// retired-instruction counter. Optional MC_CTRL_ILLEGAL_TRAP_EN adds a sticky illegal
// flag and a HALT state entered on unsupported encodings.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_code,
  input  logic [5:0]       func,
  input  logic             ZF,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic [1:0]       PC_s,
  output logic             IR_Write,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic [2:0]       ALU_OP,
  output logic             alu_a_s,
  output logic [1:0]       alu_b_s,
  output logic             imm_s,
  output logic             rd_rt_s,
  output logic             alu_mem_s,
  output logic [2:0]       state,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] inst_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  inst_cls_e  dec_cls;
  logic [2:0] dec_alu_op;
  logic       dec_imm_s;

  logic pc_write_raw, ir_write_raw, write_reg_raw, mem_write_raw;

  mc_decode u_decode (
    .op_code_i (op_code),
    .func_i    (func),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .imm_s_o   (dec_imm_s)
  );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state and per-state output decode.
  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    write_reg_raw = 1'b0;
    mem_write_raw = 1'b0;
    PC_s          = PcSelSeq;
    ALU_OP        = AluAnd;
    alu_a_s       = 1'b0;
    alu_b_s       = AluBRt;
    imm_s         = 1'b0;
    rd_rt_s       = 1'b0;
    alu_mem_s     = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    unique case (state_q)
      StIf: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_b_s      = AluBFour;
        ALU_OP       = AluAdd;
        state_d      = StId;
      end
      StId: begin
        // Branch target is computed speculatively into ALUOut for every instruction.
        alu_b_s = AluBImmSh2;
        imm_s   = 1'b1;
        ALU_OP  = AluAdd;
        if (dec_cls == ClsJ) begin
          pc_write_raw = 1'b1;
          PC_s         = PcSelJump;
          state_d      = StIf;
        end else if (dec_cls == ClsIllegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = StHalt;
`else
          state_d   = StIf;
`endif
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        case (dec_cls)
          ClsR: begin
            alu_a_s = 1'b1;
            alu_b_s = AluBRt;
            ALU_OP  = dec_alu_op;
            state_d = StWb;
          end
          ClsIArith: begin
            alu_a_s = 1'b1;
            alu_b_s = AluBImm;
            imm_s   = dec_imm_s;
            ALU_OP  = dec_alu_op;
            state_d = StWb;
          end
          ClsLw, ClsSw: begin
            alu_a_s = 1'b1;
            alu_b_s = AluBImm;
            imm_s   = 1'b1;
            ALU_OP  = AluAdd;
            state_d = StMem;
          end
          ClsBeq, ClsBne: begin
            alu_a_s      = 1'b1;
            alu_b_s      = AluBRt;
            ALU_OP       = AluSub;
            PC_s         = PcSelBranch;
            pc_write_raw = (dec_cls == ClsBeq) ? ZF : ~ZF;
            state_d      = StIf;
          end
          default: state_d = StIf;
        endcase
      end
      StMem: begin
        mem_write_raw = (dec_cls == ClsSw);
        if (mem_ready) begin
          state_d = (dec_cls == ClsLw) ? StWb : StIf;
        end
      end
      StWb: begin
        write_reg_raw = 1'b1;
        rd_rt_s       = (dec_cls != ClsR);
        alu_mem_s     = (dec_cls == ClsLw);
        state_d       = StIf;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIf;
    endcase
  end

  // Count each instruction retired, i.e. each return to IF from a working state.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StIf && state_q != StIf && state_q != StHalt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

  // Reset holds state in IF, whose decode would otherwise assert IR/PC writes.
  assign PC_Write  = pc_write_raw & rst_n;
  assign IR_Write  = ir_write_raw & rst_n;
  assign Write_Reg = write_reg_raw & rst_n;
  assign Mem_Write = mem_write_raw & rst_n;

  assign state    = state_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase model, randomized instruction
// stream, mem_ready stalls, mid-instruction reset and counter wrap (CNT_W = 4).
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  // Instruction kinds as the bench sees them
  localparam int KR = 0, KADDI = 1, KANDI = 2, KXORI = 3, KSLTIU = 4, KLW = 5, KSW = 6;
  localparam int KBEQ = 7, KBNE = 8, KJ = 9, KNOP = 10;

  localparam logic [5:0] FN_TAB [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                        6'b100110, 6'b100111, 6'b101011, 6'b000100};
  localparam logic [2:0] AL_TAB [8] = '{3'b100, 3'b101, 3'b000, 3'b001,
                                        3'b010, 3'b011, 3'b110, 3'b111};
  localparam logic [5:0] OP_TAB [11] = '{6'b000000, 6'b001000, 6'b001100, 6'b001110,
                                         6'b001011, 6'b100011, 6'b101011, 6'b000100,
                                         6'b000101, 6'b000010, 6'b111111};

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op_code, func;
  logic ZF, mem_ready;
  logic PC_Write, IR_Write, Write_Reg, Mem_Write;
  logic [1:0] PC_s, alu_b_s;
  logic [2:0] ALU_OP, state;
  logic alu_a_s, imm_s, rd_rt_s, alu_mem_s;
  logic [CW-1:0] inst_cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal;
  logic exp_illegal;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_code   (op_code),
    .func      (func),
    .ZF        (ZF),
    .mem_ready (mem_ready),
    .PC_Write  (PC_Write),
    .PC_s      (PC_s),
    .IR_Write  (IR_Write),
    .Write_Reg (Write_Reg),
    .Mem_Write (Mem_Write),
    .ALU_OP    (ALU_OP),
    .alu_a_s   (alu_a_s),
    .alu_b_s   (alu_b_s),
    .imm_s     (imm_s),
    .rd_rt_s   (rd_rt_s),
    .alu_mem_s (alu_mem_s),
    .state     (state),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal   (illegal),
`endif
    .inst_cnt  (inst_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       wr;
    logic       mw;
    logic [2:0] alu;
    logic       as;
    logic [1:0] bs;
    logic       imm;
    logic       rdrt;
    logic       am;
  } obs_t;

  obs_t got_o, exp_o;
  assign got_o = {state, PC_Write, PC_s, IR_Write, Write_Reg, Mem_Write, ALU_OP, alu_a_s,
                  alu_b_s, imm_s, rd_rt_s, alu_mem_s};

  logic [CW-1:0] exp_cnt, cnt_model;
  logic          chk_en = 1'b0;
  int            vectors = 0, miscompares = 0;

  // State log (written by the compare process) and literal-check mailbox.
  int    log_st [4096];
  int    log_n = 0;
  string lit_name [64];
  int    lit_got [64], lit_exp [64];
  int    lit_wr = 0, lit_rd = 0;

  // Expected outputs for one cycle of an instruction in a given phase (phase == state code).
  function automatic obs_t model(int ph, int kind, logic [2:0] ralu, logic zf);
    obs_t o;
    o    = '0;
    o.st = ph[2:0];
    case (ph)
      0: begin o.irw = 1; o.pcw = 1; o.bs = 2'b01; o.alu = 3'b100; end
      1: begin
        o.bs = 2'b11; o.imm = 1; o.alu = 3'b100;
        if (kind == KJ) begin o.pcw = 1; o.pcs = 2'b10; end
      end
      2: begin
        o.as = 1;
        case (kind)
          KR:     begin o.bs = 2'b00; o.alu = ralu; end
          KADDI:  begin o.bs = 2'b10; o.imm = 1; o.alu = 3'b100; end
          KANDI:  begin o.bs = 2'b10; o.imm = 0; o.alu = 3'b000; end
          KXORI:  begin o.bs = 2'b10; o.imm = 0; o.alu = 3'b010; end
          KSLTIU: begin o.bs = 2'b10; o.imm = 0; o.alu = 3'b110; end
          KLW, KSW: begin o.bs = 2'b10; o.imm = 1; o.alu = 3'b100; end
          KBEQ, KBNE: begin
            o.bs = 2'b00; o.alu = 3'b101; o.pcs = 2'b01;
            o.pcw = (kind == KBEQ) ? zf : ~zf;
          end
          default: ;
        endcase
      end
      3: o.mw = (kind == KSW);
      4: begin o.wr = 1; o.rdrt = (kind != KR); o.am = (kind == KLW); end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t reset_exp();
    obs_t o;
    o     = model(0, KNOP, 3'b000, 1'b0);
    o.pcw = 1'b0;
    o.irw = 1'b0;
    return o;
  endfunction

  task automatic lit(input string nm, input int got, input int exp);
    if (lit_wr < 64) begin
      lit_name[lit_wr] = nm;
      lit_got[lit_wr]  = got;
      lit_exp[lit_wr]  = exp;
      lit_wr++;
    end
  endtask

  function automatic int pack_states(int start, int len);
    int v;
    v = 0;
    for (int i = 0; i < len; i++) v = (v << 3) | log_st[start + i];
    return v;
  endfunction

  // Single compare process: every checked cycle plus queued literal expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (got_o !== exp_o) begin
          miscompares++;
          $display("FAIL outputs t=%0t got=%b required=%b", $time, got_o, exp_o);
        end
        vectors++;
        if (inst_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL inst_cnt t=%0t got=%0d required=%0d", $time, inst_cnt, exp_cnt);
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        vectors++;
        if (illegal !== exp_illegal) begin
          miscompares++;
          $display("FAIL illegal t=%0t got=%b required=%b", $time, illegal, exp_illegal);
        end
`endif
        if (log_n < 4096) begin
          log_st[log_n] = int'(state);
          log_n++;
        end
      end
      while (lit_rd < lit_wr) begin
        vectors++;
        if (lit_got[lit_rd] != lit_exp[lit_rd]) begin
          miscompares++;
          $display("FAIL %s got=%0d required=%0d", lit_name[lit_rd], lit_got[lit_rd],
                   lit_exp[lit_rd]);
        end
        lit_rd++;
      end
    end
  end

  // Hold reset for two edges, then release just after a rising edge.
  task automatic do_reset();
    rst_n   = 1'b0;
    exp_o   = reset_exp();
    exp_cnt = '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    exp_illegal = 1'b0;
`endif
    chk_en  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    cnt_model = '0;
    exp_cnt   = '0;
  endtask

  // Run one instruction from its IF cycle; abort_at >= 0 asserts reset in that phase index.
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input logic [2:0] ralu, input logic zf, input int waits,
                           input int abort_at, output int start);
    int ph[$];
    int mem_left;
    ph.push_back(0);
    ph.push_back(1);
    case (kind)
      KR, KADDI, KANDI, KXORI, KSLTIU: begin ph.push_back(2); ph.push_back(4); end
      KLW: begin
        ph.push_back(2);
        for (int i = 0; i <= waits; i++) ph.push_back(3);
        ph.push_back(4);
      end
      KSW: begin
        ph.push_back(2);
        for (int i = 0; i <= waits; i++) ph.push_back(3);
      end
      KBEQ, KBNE: ph.push_back(2);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      KNOP: for (int i = 0; i < 4; i++) ph.push_back(5);
`endif
      default: ;
    endcase
    start    = log_n;
    mem_left = waits;
    op_code  = op;
    func     = fn;
    foreach (ph[i]) begin
      mem_ready = 1'($urandom_range(0, 1));
      ZF        = 1'($urandom_range(0, 1));
      if (ph[i] == 3) begin
        mem_ready = (mem_left == 0);
        if (mem_left > 0) mem_left--;
      end
      if (ph[i] == 2) ZF = zf;
      exp_o   = model(ph[i], kind, ralu, zf);
      exp_cnt = cnt_model;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      exp_illegal = (ph[i] == 5);
`endif
      if (i == abort_at) begin
        #2;
        rst_n   = 1'b0;
        exp_o   = reset_exp();
        exp_cnt = '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        exp_illegal = 1'b0;
`endif
        #1;
        lit("abort_mem_write", int'(Mem_Write), 0);
        lit("abort_state", int'(state), 0);
        lit("abort_inst_cnt", int'(inst_cnt), 0);
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (kind == KNOP) return;
`endif
    cnt_model = cnt_model + 1'b1;
  endtask

  task automatic pick(output int kind, output logic [5:0] op, output logic [5:0] fn,
                      output logic [2:0] ralu);
    int r;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    kind = $urandom_range(0, 9);
`else
    kind = $urandom_range(0, 10);
`endif
    op   = OP_TAB[kind];
    fn   = 6'($urandom);
    ralu = 3'b000;
    if (kind == KR) begin
      r    = $urandom_range(0, 7);
      fn   = FN_TAB[r];
      ralu = AL_TAB[r];
    end else if (kind == KNOP) begin
      r = $urandom_range(0, 2);
      if (r == 1) op = 6'b000011;
      if (r == 2) begin op = 6'b000000; fn = 6'b001000; end
    end
  endtask

  initial begin
    int s, kind;
    logic [5:0] op, fn;
    logic [2:0] ralu;
    op_code   = '0;
    func      = '0;
    ZF        = 1'b0;
    mem_ready = 1'b1;
    cnt_model = '0;
    do_reset();

    // add $3,$1,$2
    run_instr(KR, 6'b000000, 6'b100000, 3'b100, 1'b0, 0, -1, s);
    lit("add_len", log_n - s, 4);
    lit("add_states", pack_states(s, 4), 84);  // 0,1,2,4
    lit("add_cnt", int'(inst_cnt), 1);
    // lw with three stall cycles
    run_instr(KLW, 6'b100011, 6'b010101, 3'b000, 1'b0, 3, -1, s);
    lit("lw_len", log_n - s, 8);
    lit("lw_cnt", int'(inst_cnt), 2);
    // sw, no stall
    run_instr(KSW, 6'b101011, 6'b000000, 3'b000, 1'b1, 0, -1, s);
    lit("sw_len", log_n - s, 4);
    // beq taken then not taken
    run_instr(KBEQ, 6'b000100, 6'b000000, 3'b000, 1'b1, 0, -1, s);
    lit("beq_taken_len", log_n - s, 3);
    run_instr(KBEQ, 6'b000100, 6'b000000, 3'b000, 1'b0, 0, -1, s);
    lit("beq_not_taken_len", log_n - s, 3);
    // j
    run_instr(KJ, 6'b000010, 6'b111111, 3'b000, 1'b0, 0, -1, s);
    lit("j_len", log_n - s, 2);
    lit("j_cnt", int'(inst_cnt), 6);

    // 60 random instructions: 66 retired in total wraps the 4-bit counter to 2
    for (int n = 0; n < 60; n++) begin
      pick(kind, op, fn, ralu);
      run_instr(kind, op, fn, ralu, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, s);
    end
    lit("wrap_cnt", int'(inst_cnt), 2);

    // Reset in the second MEM cycle of a stalled sw
    run_instr(KSW, 6'b101011, 6'b000000, 3'b000, 1'b0, 3, 4, s);
    run_instr(KR, 6'b000000, 6'b100010, 3'b101, 1'b1, 0, -1, s);
    lit("post_reset_cnt", int'(inst_cnt), 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run_instr(KNOP, 6'b111111, 6'b000000, 3'b000, 1'b0, 0, -1, s);
    lit("halt_state", int'(state), 5);
    lit("halt_illegal", int'(illegal), 1);
    lit("halt_cnt", int'(inst_cnt), 1);
    do_reset();
    lit("illegal_cleared", int'(illegal), 0);
`endif

    chk_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-subset datapath: ALU, register file, instruction ROM, data RAM.
- Replaces the single-cycle combinational decode with a state machine that sequences IF/ID/EX/MEM/WB over one shared ALU.
- Drives every datapath write strobe and mux select.
- Waits on a RAM ready handshake and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter inst_cnt

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
op_code  in  6  IR[31:26], from externally held IR
func  in  6  IR[5:0]
ZF  in  1  ALU zero flag, combinational, current cycle
mem_ready  in  1  RAM access complete; tie 1 for single-cycle RAM
PC_Write  out  1  PC load enable
PC_s  out  2  PC source: 00 ALU_F (PC+4), 01 ALUOut (branch target), 10 jump {PC[31:28],IR[25:0],2'b00}
IR_Write  out  1  IR load enable
Write_Reg  out  1  register file write enable
Mem_Write  out  1  RAM write enable
ALU_OP  out  3  100 add, 101 sub, 000 and, 001 or, 010 xor, 011 nor, 110 slt, 111 sll
alu_a_s  out  1  0 PC, 1 rs data
alu_b_s  out  2  00 rt data, 01 constant 4, 10 imm_Data, 11 imm_Data<<2
imm_s  out  1  1 sign-extend, 0 zero-extend
rd_rt_s  out  1  write address: 0 rd, 1 rt
alu_mem_s  out  1  write data: 0 ALUOut, 1 MDR
state  out  3  current state, for debug/LEDs
inst_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5 (HALT only with optional feature).
- Outputs decode from state plus op_code/func. Any unlisted output is 0 in that state.
- Reset: state=IF, inst_cnt=0. While rst_n=0, all strobes (PC_Write, IR_Write, Write_Reg, Mem_Write) are forced 0.
- Reset mid-instruction abandons it; no partial write after release.
- IF: IR_Write=1, PC_Write=1, PC_s=00, alu_a_s=0, alu_b_s=01, ALU_OP=100. Next state ID.
- ID: alu_a_s=0, alu_b_s=11, imm_s=1, ALU_OP=100 (branch target into ALUOut).
  - j (000010): PC_Write=1, PC_s=10, next IF.
  - Unsupported op or R-func: next IF, no strobes (NOP).
  - Otherwise next EX.
- EX, R-type (func 100000/100010/100100/100101/100110/100111/101011/000100): alu_a_s=1, alu_b_s=00, ALU_OP per func (add, sub, and, or, xor, nor, slt, sll). Next WB.
- EX, addi (001000): imm_s=1, ALU_OP 100. andi (001100): imm_s=0, ALU_OP 000. xori (001110): imm_s=0, ALU_OP 010. sltiu (001011): imm_s=0, ALU_OP 110. For all four: alu_a_s=1, alu_b_s=10, next WB.
- EX, lw (100011) / sw (101011): alu_a_s=1, alu_b_s=10, imm_s=1, ALU_OP=100. Next MEM.
- EX, beq (000100): alu_a_s=1, alu_b_s=00, ALU_OP=101, PC_s=01, PC_Write=ZF. Next IF.
- EX, bne (000101): same as beq but PC_Write=~ZF. Next IF.
- MEM: sw holds Mem_Write=1 every cycle until mem_ready=1. lw drives no strobe.
  - mem_ready=0: stay in MEM.
  - mem_ready=1: lw goes to WB, sw goes to IF.
  - mem_ready sampled only in MEM; ignored elsewhere.
- WB: Write_Reg=1.
  - R-type: rd_rt_s=0, alu_mem_s=0.
  - I-type arithmetic: rd_rt_s=1, alu_mem_s=0.
  - lw: rd_rt_s=1, alu_mem_s=1.
  - Next IF.
- inst_cnt increments by 1 on every transition into IF from ID, EX, MEM or WB, including NOP and not-taken branch. Wraps 2^CNT_W-1 to 0.
- Latency (mem_ready=1): j/NOP 2, beq/bne 3, sw 4, R-type/I-type 4, lw 5 cycles.

Optional Feature:
- MC_CTRL_ILLEGAL_TRAP_EN defined: adds port illegal (out, 1, sticky). An unsupported op/func in ID sets illegal=1, enters HALT, and does not increment inst_cnt. HALT drives no strobes and exits only via reset; reset clears illegal.
- Undefined: no illegal port, no HALT state; unsupported encodings are NOPs as above.

Decomposition:
- Package mc_pkg:
  - state encodings
  - opcode and func constants
  - ALU_OP encodings
  - PC_s and alu_b_s select encodings
- One combinational sub-module, mc_decode: op_code/func -> instruction class (R, IARITH, LW, SW, BEQ, BNE, J, ILLEGAL), ALU_OP for EX, imm_s.
- mc_ctrl holds the FSM, output decode and counter.

Test Plan:
- Reset release, mem_ready=1, add $3,$1,$2 -> states 0,1,2,4,0; WB Write_Reg=1, rd_rt_s=0, ALU_OP=100 in EX; inst_cnt=1.
- lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, no Write_Reg until WB, alu_mem_s=1 in WB; total 8 cycles; inst_cnt +1.
- sw, mem_ready=1 -> Mem_Write=1 for exactly one cycle in MEM, never Write_Reg, returns IF after 4 cycles.
- beq with ZF=1 then ZF=0 -> PC_Write=1, PC_s=01 in EX for first; PC_Write=0 for second; both counted.
- j -> PC_Write=1, PC_s=10 in ID, back to IF in 2 cycles. Preload inst_cnt near 2^CNT_W-1 with CNT_W=4 -> wraps 15->0.
- rst_n low during MEM of sw -> Mem_Write drops same cycle, state=IF, inst_cnt=0. With MC_CTRL_ILLEGAL_TRAP_EN, op_code 111111 -> state=5, illegal=1, no strobes until reset.
